// File: rtl/cpe_column_ctrl.sv
// cpe_column_ctrl: sequencer for one column of ROWS chained compensation PEs.
// It preloads the 4-bit compensation weights down the weight-pass chain, bottom
// row first. It then pops N activation vectors from the feeder, applies per-row
// systolic skew, and flags valid compensation sums at the column bottom.
//
// Ports:
//   clk, rst              clock; synchronous active-high reset
//   start                 1-cycle tile start pulse, honoured only when idle
//   cw_base, num_vec      weight base address and vector count, sampled on start
//   cw_rd_en, cw_addr     compensation memory read port
//   cw_rd_data            memory read data, one cycle after cw_rd_en
//   cw_data, cw_valid     weight and shift enable into the CPE column
//   act_avail, act_rd_en  activation feeder handshake (pop is same-cycle)
//   act_valid[ROWS]       skewed per-row activation valid
//   out_valid             bottom CPE output valid
//   busy, done            tile status

module cpe_column_ctrl #(
    parameter int unsigned ROWS   = 8,
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] cw_base,
    input  logic [CNT_W-1:0]  num_vec,
    output logic              cw_rd_en,
    output logic [ADDR_W-1:0] cw_addr,
    input  logic [3:0]        cw_rd_data,
    output logic [3:0]        cw_data,
    output logic              cw_valid,
    input  logic              act_avail,
    output logic              act_rd_en,
    output logic [ROWS-1:0]   act_valid,
    output logic              out_valid,
    output logic              busy,
    output logic              done
);

    localparam int unsigned LCNT_W = $clog2(ROWS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_WLAT,
        S_COMPUTE,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t             state, state_nxt;
    logic [LCNT_W-1:0]  lcnt, lcnt_nxt;
    logic [CNT_W-1:0]   pcnt, pcnt_nxt;
    logic [CNT_W-1:0]   ocnt, ocnt_nxt;
    logic [CNT_W-1:0]   nvec, nvec_nxt;
    logic [ADDR_W-1:0]  addr_nxt;
    logic [CNT_W-1:0]   pcnt_inc;
    logic [CNT_W-1:0]   ocnt_inc;

    assign pcnt_inc = pcnt + CNT_W'(1);
    assign ocnt_inc = ocnt + CNT_W'(1);

    // Weight pass-through; gated so the chain sees zero outside shift cycles.
    assign cw_data = cw_valid ? cw_rd_data : 4'd0;

    // Next-state, counters and the combinational feeder pop.
    always_comb begin
        state_nxt = state;
        lcnt_nxt  = lcnt;
        pcnt_nxt  = pcnt;
        ocnt_nxt  = ocnt;
        nvec_nxt  = nvec;
        addr_nxt  = cw_addr;
        act_rd_en = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = S_LOAD;
                    nvec_nxt  = num_vec;
                    addr_nxt  = cw_base + ADDR_W'(ROWS - 1);
                    lcnt_nxt  = '0;
                    pcnt_nxt  = '0;
                    ocnt_nxt  = '0;
                end
            end
            S_LOAD: begin
                // Bottom row's weight is read first so it travels furthest.
                if (lcnt == LCNT_W'(ROWS - 1)) begin
                    state_nxt = S_WLAT;
                end else begin
                    lcnt_nxt = lcnt + LCNT_W'(1);
                    addr_nxt = cw_addr - ADDR_W'(1);
                end
            end
            S_WLAT: begin
                state_nxt = (nvec == '0) ? S_DONE : S_COMPUTE;
            end
            S_COMPUTE: begin
                // Early results can already emerge here when the feeder stalls.
                if (out_valid) ocnt_nxt = ocnt_inc;
                if (act_avail) begin
                    act_rd_en = 1'b1;
                    pcnt_nxt  = pcnt_inc;
                    if (pcnt_inc == nvec) state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (out_valid) begin
                    ocnt_nxt = ocnt_inc;
                    if (ocnt_inc == nvec) state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // State, counters, skew chain and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            lcnt      <= '0;
            pcnt      <= '0;
            ocnt      <= '0;
            nvec      <= '0;
            cw_addr   <= '0;
            cw_rd_en  <= 1'b0;
            cw_valid  <= 1'b0;
            act_valid <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_nxt;
            lcnt      <= lcnt_nxt;
            pcnt      <= pcnt_nxt;
            ocnt      <= ocnt_nxt;
            nvec      <= nvec_nxt;
            cw_addr   <= addr_nxt;
            cw_rd_en  <= (state_nxt == S_LOAD);
            cw_valid  <= cw_rd_en;
            act_valid <= {act_valid[ROWS-2:0], act_rd_en};
            out_valid <= act_valid[ROWS-1];
            busy      <= (state_nxt != S_IDLE);
            done      <= (state_nxt == S_DONE);
        end
    end

endmodule

// File: tb/tb_cpe_column_ctrl.sv
// Self-checking bench for cpe_column_ctrl with ROWS=4: table of tile scenarios
// checked cycle by cycle, plus a hand-written mid-tile reset sequence.

module tb_cpe_column_ctrl;

    localparam int unsigned ROWS   = 4;
    localparam int unsigned ADDR_W = 8;
    localparam int unsigned CNT_W  = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [ADDR_W-1:0] cw_base;
    logic [CNT_W-1:0]  num_vec;
    logic              cw_rd_en;
    logic [ADDR_W-1:0] cw_addr;
    logic [3:0]        cw_rd_data;
    logic [3:0]        cw_data;
    logic              cw_valid;
    logic              act_avail;
    logic              act_rd_en;
    logic [ROWS-1:0]   act_valid;
    logic              out_valid;
    logic              busy;
    logic              done;

    cpe_column_ctrl #(.ROWS(ROWS), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .cw_base    (cw_base),
        .num_vec    (num_vec),
        .cw_rd_en   (cw_rd_en),
        .cw_addr    (cw_addr),
        .cw_rd_data (cw_rd_data),
        .cw_data    (cw_data),
        .cw_valid   (cw_valid),
        .act_avail  (act_avail),
        .act_rd_en  (act_rd_en),
        .act_valid  (act_valid),
        .out_valid  (out_valid),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    // Compensation memory model: one-cycle read latency.
    logic [3:0] mem [256];
    always @(posedge clk) begin
        if (rst)           cw_rd_data <= 4'd0;
        else if (cw_rd_en) cw_rd_data <= mem[cw_addr];
    end

    typedef struct {
        logic [7:0] base;
        int         n;
        int         stall_lo;     // act_avail held low over [stall_lo, stall_hi]
        int         stall_hi;
        int         restart_cyc;  // cycle with a spurious start pulse, -1 none
        int         exp_done;     // expected done cycle
        int         exp_outs;     // expected out_valid count
    } vec_t;

    vec_t       tbl [6];
    int         nvec_applied = 0;
    int         nmiss = 0;
    logic [3:0] sb [$];
    bit         pop_m [0:127];

    task automatic check(input string name, input int c, input int act, input int exp);
        nvec_applied++;
        if (act !== exp) begin
            nmiss++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", name, c, act, exp);
        end
    endtask

    function automatic bit popped(input int c);
        if (c < 0 || c > 127) return 1'b0;
        return pop_m[c];
    endfunction

    task automatic check_idle(input string tag);
        check({tag, "_rd_en"},     0, int'(cw_rd_en),  0);
        check({tag, "_addr"},      0, int'(cw_addr),   0);
        check({tag, "_cw_valid"},  0, int'(cw_valid),  0);
        check({tag, "_cw_data"},   0, int'(cw_data),   0);
        check({tag, "_act_rd_en"}, 0, int'(act_rd_en), 0);
        check({tag, "_act_valid"}, 0, int'(act_valid), 0);
        check({tag, "_out_valid"}, 0, int'(out_valid), 0);
        check({tag, "_busy"},      0, int'(busy),      0);
        check({tag, "_done"},      0, int'(done),      0);
    endtask

    // Start a tile in cycle 0 and check every output in cycles 1..done+3.
    task automatic run_tile(input vec_t v);
        int         pops;
        int         last;
        int         model_done;
        int         done_seen;
        int         outs;
        bit         exp_rd;
        bit         avail;
        logic [7:0] a;
        logic [3:0] w;

        for (int i = 0; i < 128; i++) pop_m[i] = 1'b0;
        pops = 0;
        last = 0;
        for (int c = ROWS + 2; pops < v.n && c < 100; c++) begin
            if (!(c >= v.stall_lo && c <= v.stall_hi)) begin
                pop_m[c] = 1'b1;
                pops++;
                last = c;
            end
        end
        model_done = (v.n == 0) ? ROWS + 2 : last + ROWS + 2;

        @(negedge clk);
        start     = 1'b1;
        cw_base   = v.base;
        num_vec   = CNT_W'(v.n);
        act_avail = 1'b1;
        done_seen = -1;
        outs      = 0;

        for (int c = 1; c <= model_done + 3; c++) begin
            @(negedge clk);
            start     = (c == v.restart_cyc);
            cw_base   = ~v.base;
            num_vec   = 8'd5;
            avail     = !(c >= v.stall_lo && c <= v.stall_hi);
            act_avail = avail;
            #1;
            exp_rd = (c >= 1 && c <= int'(ROWS));
            check("rd_en", c, int'(cw_rd_en), int'(exp_rd));
            if (exp_rd) begin
                a = 8'(int'(v.base) + int'(ROWS) - c);
                check("addr", c, int'(cw_addr), int'(a));
                sb.push_back(mem[a]);
            end
            check("cw_valid", c, int'(cw_valid), int'(c >= 2 && c <= int'(ROWS) + 1));
            if (cw_valid) begin
                if (sb.size() == 0) begin
                    check("cw_sb_empty", c, 1, 0);
                end else begin
                    w = sb.pop_front();
                    check("cw_data", c, int'(cw_data), int'(w));
                end
            end
            check("act_rd_en", c, int'(act_rd_en), int'(popped(c)));
            for (int r = 0; r < int'(ROWS); r++)
                check($sformatf("act_valid%0d", r), c, int'(act_valid[r]), int'(popped(c - 1 - r)));
            check("out_valid", c, int'(out_valid), int'(popped(c - int'(ROWS) - 1)));
            check("busy", c, int'(busy), int'(c <= model_done));
            check("done", c, int'(done), int'(c == model_done));
            if (done && done_seen < 0) done_seen = c;
            if (out_valid) outs++;
        end
        start = 1'b0;
        check("done_cycle", 0, done_seen, v.exp_done);
        check("out_count", 0, outs, v.exp_outs);
        check("sb_left", 0, sb.size(), 0);
        sb.delete();
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 4'(i * 7 + 3);

        //          base   n  lo  hi  restart done outs
        tbl[0] = '{8'h10, 3, -1, -1, -1, 14, 3};
        tbl[1] = '{8'h10, 0, -1, -1, -1,  6, 0};
        tbl[2] = '{8'h10, 3,  7,  8, -1, 16, 3};
        tbl[3] = '{8'hFE, 2, -1, -1, -1, 13, 2};
        tbl[4] = '{8'h20, 3, -1, -1,  2, 14, 3};
        tbl[5] = '{8'h30, 1, -1, -1, 12, 12, 1};

        rst       = 1'b1;
        start     = 1'b0;
        cw_base   = '0;
        num_vec   = '0;
        act_avail = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_idle("reset");
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 6; i++) run_tile(tbl[i]);

        // Reset during COMPUTE abandons the tile with no done.
        @(negedge clk);
        start     = 1'b1;
        cw_base   = 8'h40;
        num_vec   = 8'd3;
        act_avail = 1'b1;
        for (int c = 1; c <= 7; c++) begin
            @(negedge clk);
            start = 1'b0;
            rst   = (c == 7);
            #1;
            if (c == 7) check("mid_busy", c, int'(busy), 1);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_idle("mid_rst");
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            #1;
            check("post_rst_done", c, int'(done), 0);
        end

        run_tile(tbl[0]);

        $display("== %0d vectors applied, %0d miscompares ==", nvec_applied, nmiss);
        $finish;
    end

endmodule
